llc_chan_sched: RTL

// - Input-channel scheduler in front of the LLC core. It arbitrates between four request sources with valid/ready handshakes:
//   rst_tb, rsp_in, req_in and dma_req_in.
// - It presents one registered grant to the core and routes the core's ready back to the granted source only.
// - It sits between the NoC-side input queues and llc_core's channel-selection stage.

---
 rtl/llc_chan_sched.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/llc_chan_sched.sv
// Four-source input-channel scheduler for llc_core with a registered grant and DMA starvation boost.
// Define LLC_SCHED_STATS_EN to add per-channel handshake counters and the stat_clear input.
module llc_chan_sched #(
    parameter int STARVE_LIMIT = 8,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             llc_rst_tb_valid,
    input  logic             llc_rsp_in_valid,
    input  logic             llc_req_in_valid,
    input  logic             llc_dma_req_in_valid,
    output logic             llc_rst_tb_ready,
    output logic             llc_rsp_in_ready,
    output logic             llc_req_in_ready,
    output logic             llc_dma_req_in_ready,
    input  logic             core_busy,
    output logic             sel_valid,
    output logic [1:0]       sel_chan,
    input  logic             sel_ready,
    output logic             dma_boost
`ifdef LLC_SCHED_STATS_EN
    ,
    input  logic             stat_clear,
    output logic [CNT_W-1:0] stat_rst_tb_cnt,
    output logic [CNT_W-1:0] stat_rsp_cnt,
    output logic [CNT_W-1:0] stat_req_cnt,
    output logic [CNT_W-1:0] stat_dma_cnt
`endif
);

    localparam logic [0:0]       IDLE  = 1'b0;
    localparam logic [0:0]       GRANT = 1'b1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    localparam logic [1:0] CH_RST = 2'd0;
    localparam logic [1:0] CH_RSP = 2'd1;
    localparam logic [1:0] CH_REQ = 2'd2;
    localparam logic [1:0] CH_DMA = 2'd3;

    logic [0:0]       state_q, state_d;
    logic [1:0]       sel_chan_q, sel_chan_d;
    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
    logic             dma_boost_q, dma_boost_d;

    logic [3:0] elig;
    logic       handshake;
    logic       win_valid;
    logic [1:0] win_chan;

    assign handshake = (state_q == GRANT) && sel_ready;

    always_comb begin
        elig = {llc_dma_req_in_valid & ~core_busy,
                llc_req_in_valid & ~core_busy,
                llc_rsp_in_valid,
                llc_rst_tb_valid & ~core_busy};

        starve_cnt_d = starve_cnt_q;
        dma_boost_d  = dma_boost_q;
        if (handshake) begin
            if (sel_chan_q == CH_DMA) begin
                starve_cnt_d = '0;
                dma_boost_d  = 1'b0;
            end else if (sel_chan_q == CH_REQ && llc_dma_req_in_valid && starve_cnt_q != LIMIT) begin
                starve_cnt_d = starve_cnt_q + CNT_W'(1);
            end
        end
        if (starve_cnt_d == LIMIT) begin
            dma_boost_d = 1'b1;
        end

        // Arbitrate with the boost that will be in force while the new grant is presented.
        win_valid = |elig;
        win_chan  = CH_RST;
        if (elig[0]) begin
            win_chan = CH_RST;
        end else if (elig[1]) begin
            win_chan = CH_RSP;
        end else if (dma_boost_d && elig[3]) begin
            win_chan = CH_DMA;
        end else if (elig[2]) begin
            win_chan = CH_REQ;
        end else if (elig[3]) begin
            win_chan = CH_DMA;
        end

        state_d    = state_q;
        sel_chan_d = sel_chan_q;
        if (state_q == IDLE || handshake) begin
            if (win_valid) begin
                state_d    = GRANT;
                sel_chan_d = win_chan;
            end else begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            sel_chan_q   <= CH_RST;
            starve_cnt_q <= '0;
            dma_boost_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_chan_q   <= sel_chan_d;
            starve_cnt_q <= starve_cnt_d;
            dma_boost_q  <= dma_boost_d;
        end
    end

    assign sel_valid = (state_q == GRANT);
    assign sel_chan  = sel_chan_q;
    assign dma_boost = dma_boost_q;

    assign llc_rst_tb_ready     = handshake && (sel_chan_q == CH_RST);
    assign llc_rsp_in_ready     = handshake && (sel_chan_q == CH_RSP);
    assign llc_req_in_ready     = handshake && (sel_chan_q == CH_REQ);
    assign llc_dma_req_in_ready = handshake && (sel_chan_q == CH_DMA);

`ifdef LLC_SCHED_STATS_EN
    logic [CNT_W-1:0] stat_cnt_q [4];
    logic [CNT_W-1:0] stat_cnt_d [4];

    // A clear wins over a coincident handshake, which is then not counted.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            stat_cnt_d[i] = stat_cnt_q[i];
            if (stat_clear) begin
                stat_cnt_d[i] = '0;
            end else if (handshake && sel_chan_q == i[1:0] && !(&stat_cnt_q[i])) begin
                stat_cnt_d[i] = stat_cnt_q[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                stat_cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                stat_cnt_q[i] <= stat_cnt_d[i];
            end
        end
    end

    assign stat_rst_tb_cnt = stat_cnt_q[0];
    assign stat_rsp_cnt    = stat_cnt_q[1];
    assign stat_req_cnt    = stat_cnt_q[2];
    assign stat_dma_cnt    = stat_cnt_q[3];
`endif

endmodule
